// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller in front of a simple dual-port RAM, with a first-word-fall-through output register.
// Optional synchronous clear port flush_i is enabled with `define SYNC_FIFO_CTRL_FLUSH_EN.
module sync_fifo_ctrl #(
    parameter  int DWIDTH = 64,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 2)
) (
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef SYNC_FIFO_CTRL_FLUSH_EN
    input  logic              flush_i,
`endif
    input  logic [DWIDTH-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [DWIDTH-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DWIDTH-1:0] ram_wr_data_o,
    output logic [AW-1:0]     ram_wr_addr_o,
    output logic              ram_wr_en_o,
    output logic [AW-1:0]     ram_rd_addr_o,
    input  logic [DWIDTH-1:0] ram_rd_data_i,
    output logic [CW-1:0]     count_o
);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              m_valid_q, m_valid_d;
    logic [DWIDTH-1:0] m_data_q, m_data_d;

    logic ram_empty;
    logic ram_full;
    logic flush;
    logic wr_fire;
    logic rd_fire;
    logic load;

`ifdef SYNC_FIFO_CTRL_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign ram_empty = (wr_ptr_q == rd_ptr_q);
    assign ram_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Ready comes only from registers and reset, so a slot freed by this cycle's load is usable next cycle.
    assign s_ready_o = !rst_i && !ram_full && !flush;
    assign wr_fire   = s_valid_i && s_ready_o;
    assign rd_fire   = m_valid_q && m_ready_i && !flush;
    assign load      = !ram_empty && (!m_valid_q || m_ready_i) && !flush;

    assign ram_wr_en_o   = wr_fire;
    assign ram_wr_addr_o = wr_ptr_q[AW-1:0];
    assign ram_wr_data_o = s_data_i;
    assign ram_rd_addr_o = rd_ptr_q[AW-1:0];

    assign m_data_o  = m_data_q;
    assign m_valid_o = m_valid_q;
    assign count_o   = count_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end

        if (load) begin
            m_data_d  = ram_rd_data_i;
            m_valid_d = 1'b1;
            rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else if (rd_fire) begin
            m_valid_d = 1'b0;
        end

        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase

        // Flush discards contents but keeps the stale output word; m_valid_q masks it.
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            m_valid_d = 1'b0;
            m_data_d  = m_data_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl (DEPTH=4) with a behavioural dual-port RAM.
module tb_sync_fifo_ctrl;

    localparam int DW = 64;
    localparam int DP = 4;
    localparam int AW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
`ifdef SYNC_FIFO_CTRL_FLUSH_EN
    logic          flush;
`endif
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_wr_addr;
    logic          ram_wr_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [DP];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end
    assign ram_rd_data = mem[ram_rd_addr];

    sync_fifo_ctrl #(.DWIDTH(DW), .DEPTH(DP)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
`ifdef SYNC_FIFO_CTRL_FLUSH_EN
        .flush_i       (flush),
`endif
        .s_data_i      (s_data),
        .s_valid_i     (s_valid),
        .s_ready_o     (s_ready),
        .m_data_o      (m_data),
        .m_valid_o     (m_valid),
        .m_ready_i     (m_ready),
        .ram_wr_data_o (ram_wr_data),
        .ram_wr_addr_o (ram_wr_addr),
        .ram_wr_en_o   (ram_wr_en),
        .ram_rd_addr_o (ram_rd_addr),
        .ram_rd_data_i (ram_rd_data),
        .count_o       (count)
    );

`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp); \
        end \
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_word;
    int            mcount;
    int            sent;
    int            recv;
    logic          fw, fr;

    initial begin
        for (int i = 0; i < DP; i++) mem[i] = '0;
        rst = 1'b1; s_valid = 1'b1; s_data = 64'hDEAD; m_ready = 1'b0;
`ifdef SYNC_FIFO_CTRL_FLUSH_EN
        flush = 1'b0;
`endif

        // 1. reset
        for (int c = 0; c < 3; c++) begin
            tick();
            `CHK("rst_s_ready", s_ready, 1'b0)
            `CHK("rst_wr_en", ram_wr_en, 1'b0)
            `CHK("rst_m_valid", m_valid, 1'b0)
            `CHK("rst_count", count, 3'd0)
        end
        rst = 1'b0; s_valid = 1'b0;
        tick();
        `CHK("rel_s_ready", s_ready, 1'b1)
        `CHK("rel_count", count, 3'd0)

        // 2. latency
        s_valid = 1'b1; s_data = 64'hA5; m_ready = 1'b0;
        #1;
        `CHK("lat_wr_en", ram_wr_en, 1'b1)
        `CHK("lat_wr_addr", ram_wr_addr, 2'd0)
        `CHK("lat_wr_data", ram_wr_data, 64'hA5)
        tick();
        s_valid = 1'b0;
        `CHK("lat_c1_count", count, 3'd1)
        `CHK("lat_c1_m_valid", m_valid, 1'b0)
        tick();
        `CHK("lat_c2_m_valid", m_valid, 1'b1)
        `CHK("lat_c2_m_data", m_data, 64'hA5)
        `CHK("lat_c2_count", count, 3'd1)
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        `CHK("lat_drain_m_valid", m_valid, 1'b0)
        `CHK("lat_drain_count", count, 3'd0)

        // 3. fill to DEPTH+1
        for (int c = 0; c < 6; c++) begin
            s_valid = 1'b1; s_data = 64'(c + 1);
            #1;
            `CHK("fill_s_ready", s_ready, (c < 5))
            tick();
        end
        `CHK("fill_count", count, 3'd5)
        `CHK("fill_m_data", m_data, 64'd1)
        `CHK("fill_s_ready_full", s_ready, 1'b0)
        m_ready = 1'b1;
        #1;
        `CHK("fill_pop_s_ready", s_ready, 1'b0)
        tick();
        m_ready = 1'b0;
        #1;
        `CHK("fill_after_pop_s_ready", s_ready, 1'b1)
        `CHK("fill_after_pop_wr_en", ram_wr_en, 1'b1)
        `CHK("fill_after_pop_m_data", m_data, 64'd2)
        tick();
        s_valid = 1'b0;
        `CHK("fill_refill_count", count, 3'd5)
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            `CHK("fill_drain_m_valid", m_valid, 1'b1)
            `CHK("fill_drain_m_data", m_data, 64'(k + 2))
            tick();
        end
        m_ready = 1'b0;
        `CHK("fill_drained_count", count, 3'd0)
        `CHK("fill_drained_m_valid", m_valid, 1'b0)

        // 4. streaming
        m_ready = 1'b1;
        for (int c = 0; c < 102; c++) begin
            s_valid = (c < 100); s_data = 64'(c);
            #1;
            if (c >= 2) begin
                `CHK("stream_m_valid", m_valid, 1'b1)
                `CHK("stream_m_data", m_data, 64'(c - 2))
            end
            if (c >= 2 && c < 100) `CHK("stream_count", count, 3'd2)
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b0;
        `CHK("stream_end_count", count, 3'd0)
        `CHK("stream_end_m_valid", m_valid, 1'b0)

        // 5. wrap with random backpressure
        mcount = 0; sent = 0; recv = 0;
        for (int c = 0; c < 1000 && recv < 40; c++) begin
            s_valid = (sent < 40) && ($urandom_range(0, 2) != 0);
            s_data  = 64'h1000 + 64'(sent);
            m_ready = ($urandom_range(0, 2) != 0);
            #1;
            fw = s_valid && s_ready;
            fr = m_valid && m_ready;
            if (fr) begin
                exp_word = (q.size() > 0) ? q.pop_front() : 64'hBAD;
                `CHK("wrap_order", m_data, exp_word)
                recv++;
            end
            if (fw) begin
                q.push_back(s_data);
                sent++;
            end
            tick();
            mcount = mcount + int'(fw) - int'(fr);
            `CHK("wrap_count", count, 3'(mcount))
            checks++;
            assert (count <= 3'd5) else begin
                errors++;
                $error("FAIL wrap_count_max: observed %0d required <= 5", count);
            end
        end
        `CHK("wrap_recv_total", recv, 40)
        s_valid = 1'b0; m_ready = 1'b0;
        #1;
        `CHK("wrap_end_count", count, 3'd0)

        // 6. async reset mid-operation
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 64'h50 + 64'(k);
            tick();
        end
        s_valid = 1'b0;
        `CHK("mid_pre_count", count, 3'd3)
        `CHK("mid_pre_m_valid", m_valid, 1'b1)
        #2 rst = 1'b1;
        #1;
        `CHK("mid_rst_m_valid", m_valid, 1'b0)
        `CHK("mid_rst_count", count, 3'd0)
        `CHK("mid_rst_s_ready", s_ready, 1'b0)
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            `CHK("mid_post_m_valid", m_valid, 1'b0)
        end
        s_valid = 1'b1; s_data = 64'h77;
        tick();
        s_valid = 1'b0;
        tick();
        `CHK("mid_first_m_valid", m_valid, 1'b1)
        `CHK("mid_first_m_data", m_data, 64'h77)
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        `CHK("mid_end_count", count, 3'd0)

`ifdef SYNC_FIFO_CTRL_FLUSH_EN
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 64'h60 + 64'(k);
            tick();
        end
        `CHK("flush_pre_count", count, 3'd3)
        flush = 1'b1; m_ready = 1'b1; s_valid = 1'b1; s_data = 64'h99;
        #1;
        `CHK("flush_s_ready", s_ready, 1'b0)
        `CHK("flush_wr_en", ram_wr_en, 1'b0)
        tick();
        flush = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
        `CHK("flush_count", count, 3'd0)
        `CHK("flush_m_valid", m_valid, 1'b0)
        `CHK("flush_m_data_held", m_data, 64'h60)
        s_valid = 1'b1; s_data = 64'h88;
        tick();
        s_valid = 1'b0;
        tick();
        `CHK("flush_next_m_data", m_data, 64'h88)
        `CHK("flush_next_count", count, 3'd1)
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock FIFO controller that sits directly upstream of the team's simple dual-port RAM (registered write port, combinational read port) and owns its write and read ports.
- Provides valid/ready streaming on both sides and a first-word-fall-through registered output stage.
- Total capacity is DEPTH words in RAM plus 1 word in the output register.
- Serves as the sync counterpart of the async FIFO path.

Parameters:
DWIDTH, 64, data width in bits
DEPTH, 16, RAM depth in words; power of 2, >= 2; AW = $clog2(DEPTH)

Ports:
clk  input  1  single clock for all logic
rst  input  1  asynchronous reset, active-high
s_data  input  DWIDTH  write-side data
s_valid  input  1  write-side valid
s_ready  output  1  write-side ready
m_data  output  DWIDTH  read-side data (registered)
m_valid  output  1  read-side valid (registered)
m_ready  input  1  read-side ready
ram_wr_data  output  DWIDTH  to RAM write data
ram_wr_addr  output  AW  to RAM write address
ram_wr_en  output  1  to RAM write enable
ram_rd_addr  output  AW  to RAM read address
ram_rd_data  input  DWIDTH  from RAM combinational read data
count  output  $clog2(DEPTH+2)  total words held, 0..DEPTH+1 (registered)

Behaviour:
- Clock and reset are fixed: one clock, clk. rst is asynchronous and active-high.
- Pointers wr_ptr and rd_ptr are AW+1 bits wide; the MSB is the wrap bit.
  - ram_empty = (wr_ptr == rd_ptr).
  - ram_full = MSBs differ and the low AW bits are equal.
- Reset values (applied asynchronously, held while rst=1):
  - wr_ptr = 0, rd_ptr = 0, count = 0, m_valid = 0, m_data = 0.
  - s_ready = 0 and ram_wr_en = 0 while rst=1.
- s_ready = !rst && !ram_full. It depends only on registers and rst; there is no combinational path from s_valid or m_ready.
- Write: wr_fire = s_valid && s_ready.
  - ram_wr_en = wr_fire, ram_wr_addr = wr_ptr[AW-1:0], ram_wr_data = s_data.
  - wr_ptr increments on wr_fire and wraps naturally modulo 2*DEPTH.
- Read side: ram_rd_addr = rd_ptr[AW-1:0].
  - load = !ram_empty && (!m_valid || m_ready).
  - On load: m_data <= ram_rd_data, m_valid <= 1, rd_ptr++.
  - Else, if m_valid && m_ready: m_valid <= 0, and m_data holds its value.
- Latency:
  - A word written in cycle N (empty FIFO, m_ready don't-care) shows m_valid=1 in cycle N+2.
  - Sustained throughput is 1 word/cycle in both directions.
- count: +1 on wr_fire, -1 on m_valid && m_ready. Both in the same cycle means no change.
- Full case: when the RAM is full, s_ready=0 even if load frees a slot in the same cycle. s_ready rises the following cycle; there is no write-through on full.
- Empty case: load never fires while ram_empty, so a same-cycle write is never read combinationally.
- Ordering: strict FIFO order across pointer wrap.
- Reset mid-operation: all contents are discarded. m_valid drops asynchronously. No pre-reset word appears after release.

Optional Feature:
SYNC_FIFO_CTRL_FLUSH_EN
- Defined: adds port flush (input, 1), a synchronous clear.
  - In a cycle with flush=1: s_ready=0 and ram_wr_en=0.
  - At that edge: wr_ptr, rd_ptr, count and m_valid clear to 0, and m_data holds its value.
  - flush overrides any load or output handshake in the same cycle; m_ready is ignored that cycle.
  - Normal operation resumes the cycle after flush deasserts.
- Undefined: the port is absent and the logic is exactly as described under Behaviour.

Test Plan:
1. Reset: assert rst for 3 cycles with s_valid=1 -> s_ready=0, ram_wr_en=0, m_valid=0, count=0. Release -> s_ready=1 on the next cycle.
2. Latency (DEPTH=4): write 0xA5 at cycle 0, m_ready=0 -> ram_wr_en=1/addr=0 at cycle 0. m_valid=1, m_data=0xA5 from cycle 2. count=1 from cycle 1.
3. Fill (DEPTH=4, m_ready=0): s_valid=1 with data 1..6 -> data 1..5 accepted, s_ready=0 from cycle 5, count=5, m_data=1. Pop once -> s_ready=1 the next cycle and data 6 accepted.
4. Streaming: s_valid=1 and m_ready=1 continuously with data 0..99 -> output 0..99 in order, one per cycle after the 2-cycle fill, count steady at 2.
5. Wrap and backpressure (DEPTH=4): 40 words with pseudo-random s_valid/m_ready -> in-order output, no loss or duplication, count always matches a scoreboard, count never exceeds 5.
6. Mid-op reset with count=3: pulse rst asynchronously between edges -> m_valid=0 immediately. After release, m_valid stays 0 until new writes, and the first output equals the first post-reset write. With SYNC_FIFO_CTRL_FLUSH_EN, flush with count=3 -> count=0 and m_valid=0 the next cycle.
